conv_seq_ctrl: RTL

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 3x3 convolution pass: issues window coordinates in raster
// order and tracks them through a fixed-latency kernel to tag each result.
module conv_seq_ctrl #(
  parameter int KERNEL_LAT = 4,
  parameter int DIM_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             win_valid,
  output logic [5:0]       win_row,
  output logic [5:0]       win_col,
  output logic             out_valid,
  output logic [5:0]       out_row,
  output logic [5:0]       out_col,
  output logic             out_last,
  output logic [1:0]       dbg_state
);

  // Valid-only interface: win_valid and out_valid each qualify their
  // coordinate buses for exactly one cycle; there is no back-pressure.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(64);

  state_t           state;
  logic [DIM_W-1:0] width_m3;
  logic [DIM_W-1:0] height_m3;
  logic [5:0]       row_q;
  logic [5:0]       col_q;
  logic             win_last;

  logic             pipe_v    [KERNEL_LAT];
  logic [5:0]       pipe_row  [KERNEL_LAT];
  logic [5:0]       pipe_col  [KERNEL_LAT];
  logic             pipe_last [KERNEL_LAT];

  logic             cfg_legal;
  logic             at_row_end;
  logic             at_last;
  logic             pipe_any;

  assign cfg_legal = (cfg_width  >= MIN_DIM) && (cfg_width  <= MAX_DIM) &&
                     (cfg_height >= MIN_DIM) && (cfg_height <= MAX_DIM);
  assign at_row_end = (DIM_W'(col_q) == width_m3);
  assign at_last    = at_row_end && (DIM_W'(row_q) == height_m3);
  assign dbg_state  = state;

  // The registered window stage counts as in flight until it enters the pipe.
  always_comb begin
    pipe_any = win_valid;
    for (int i = 0; i < KERNEL_LAT; i++) begin
      pipe_any = pipe_any | pipe_v[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      width_m3  <= '0;
      height_m3 <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              width_m3  <= cfg_width - MIN_DIM;
              height_m3 <= cfg_height - MIN_DIM;
              row_q     <= '0;
              col_q     <= '0;
              cfg_err   <= 1'b0;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          if (!pause) begin
            win_valid <= 1'b1;
            win_row   <= row_q;
            win_col   <= col_q;
            win_last  <= at_last;
            if (at_last) begin
              state <= DRAIN;
            end else if (at_row_end) begin
              col_q <= '0;
              row_q <= row_q + 6'd1;
            end else begin
              col_q <= col_q + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (!pipe_any) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Kernel latency model: shifts every cycle, regardless of pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_LAT; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_row[i]  <= '0;
        pipe_col[i]  <= '0;
        pipe_last[i] <= 1'b0;
      end
    end else begin
      pipe_v[0]    <= win_valid;
      pipe_row[0]  <= win_row;
      pipe_col[0]  <= win_col;
      pipe_last[0] <= win_last;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_row[i]  <= pipe_row[i-1];
        pipe_col[i]  <= pipe_col[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign out_valid = pipe_v[KERNEL_LAT-1];
  assign out_row   = pipe_row[KERNEL_LAT-1];
  assign out_col   = pipe_col[KERNEL_LAT-1];
  assign out_last  = pipe_last[KERNEL_LAT-1] & pipe_v[KERNEL_LAT-1];

endmodule
